mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Shares the single line-wide backing memory between the instruction cache refill port and the
//  data cache refill/write-back port. Sits between iCache/dCache miss interfaces and memory.
//  Grants one transaction at a time, round-robin on contention, and returns the line plus a
//  one-cycle ready pulse to the winner. Counts grants for performance reporting.
// PARAMETERS
//  WORD_SIZE   32   address width in bits
//  LINE_SIZE   128  cache line width in bits; OFS = $clog2(LINE_SIZE/8) low address bits cleared
//  CNT_W       16   width of grant counters (saturating)
// PORTS
//  clk          in   1          clock, all state updates on posedge
//  rst          in   1          synchronous, active-high reset
//  ic_req       in   1          iCache line read request (level, held until ic_ready)
//  ic_addr      in   WORD_SIZE  iCache miss address, stable while ic_req
//  ic_line      out  LINE_SIZE  line returned to iCache, valid when ic_ready
//  ic_ready     out  1          one-cycle completion pulse to iCache
//  dc_rd_req    in   1          dCache line read request (level)
//  dc_wr_req    in   1          dCache line write-back request (level)
//  dc_addr      in   WORD_SIZE  dCache address, stable while a dCache request is high
//  dc_wline     in   LINE_SIZE  write-back line, stable while dc_wr_req
//  dc_line      out  LINE_SIZE  line returned to dCache, valid when dc_ready after a read
//  dc_ready     out  1          one-cycle completion pulse to dCache (read or write)
//  mem_read     out  1          memory read strobe, held until mem_ready
//  mem_write    out  1          memory write strobe, held until mem_ready
//  mem_addr     out  WORD_SIZE  line-aligned memory address
//  mem_wline    out  LINE_SIZE  write data to memory
//  mem_rline    in   LINE_SIZE  read data from memory, valid when mem_ready
//  mem_ready    in   1          memory completion pulse (one cycle)
//  ic_grants    out  CNT_W      completed iCache transactions, saturating
//  dc_grants    out  CNT_W      completed dCache transactions, saturating
//  proto_err    out  1          sticky: dc_rd_req and dc_wr_req sampled high together in IDLE
// BEHAVIOUR
//  Reset: state=IDLE, last_grant=IC; all outputs 0 (lines, strobes, pulses, counters, proto_err).
//  States: IDLE -> IC_BUSY | DC_RD | DC_WR -> DONE -> IDLE.
//  IDLE: sample requests. Only ic_req -> IC_BUSY. Only dCache -> DC_RD/DC_WR. Both -> grant the
//   side != last_grant (round-robin); last_grant updated on every grant. dc_wr_req wins over
//   dc_rd_req if both high, proto_err set.
//  BUSY states (registered outputs, first asserted the cycle after the grant decision):
//   mem_read (IC_BUSY, DC_RD) or mem_write (DC_WR) =1; mem_addr = requester addr with
//   addr[OFS-1:0]=0; mem_wline=dc_wline in DC_WR, else 0. Hold until mem_ready.
//  mem_ready in BUSY: next cycle -> DONE; strobes drop to 0; capture mem_rline into ic_line or
//   dc_line (reads only; dc_line unchanged on write); winner's ready=1; winner's counter +1
//   unless at all-ones.
//  DONE: lasts exactly 1 cycle, requests ignored (requester drops req on seeing ready); -> IDLE.
//  Latency: req seen in IDLE at cycle t -> strobe at t+1; mem_ready at k -> ready pulse at k+1;
//   earliest next strobe at k+3. ic_line/dc_line hold their value until the next capture.
//  mem_ready while IDLE or DONE: ignored. Requester dropping req mid-BUSY: transaction still
//   completes and pulses ready.
//  ic_ready and dc_ready are never high in the same cycle; never both strobes high together.
//  rst mid-transaction: abandon immediately, return to reset values (memory shares rst).
// TESTING
//  ic_req only, ic_addr=0x0000_104C, memory 3-cycle latency -> mem_read@t+1, mem_addr=0x0000_1040,
//   ic_ready pulse 1 cycle after mem_ready with ic_line=mem_rline, ic_grants=1.
//  ic_req and dc_rd_req high same cycle after reset -> DC granted first, then IC; alternate
//   for 4 back-to-back pairs; grant counts 4/4.
//  dc_wr_req, dc_wline=0xDEADBEEF_...; -> mem_write=1, mem_wline matches, dc_ready pulse,
//   dc_line unchanged, mem_read never high.
//  dc_rd_req and dc_wr_req together -> write performed, proto_err=1 and stays 1 until rst.
//  rst asserted 2 cycles into an IC_BUSY -> next cycle all outputs 0, no ic_ready pulse; a
//   stray mem_ready in IDLE afterwards produces no ready pulse.
//  Drive 2^CNT_W+3 iCache transactions (CNT_W=4 build) -> ic_grants saturates at 0xF.

Source files
------------

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one line-wide backing memory between the iCache refill port
// and the dCache refill/write-back port, with saturating per-side grant counters.
module mem_arbiter #(
    parameter int WORD_SIZE = 32,
    parameter int LINE_SIZE = 128,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ic_req,
    input  logic [WORD_SIZE-1:0] ic_addr,
    output logic [LINE_SIZE-1:0] ic_line,
    output logic                 ic_ready,
    input  logic                 dc_rd_req,
    input  logic                 dc_wr_req,
    input  logic [WORD_SIZE-1:0] dc_addr,
    input  logic [LINE_SIZE-1:0] dc_wline,
    output logic [LINE_SIZE-1:0] dc_line,
    output logic                 dc_ready,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic [WORD_SIZE-1:0] mem_addr,
    output logic [LINE_SIZE-1:0] mem_wline,
    input  logic [LINE_SIZE-1:0] mem_rline,
    input  logic                 mem_ready,
    output logic [CNT_W-1:0]     ic_grants,
    output logic [CNT_W-1:0]     dc_grants,
    output logic                 proto_err
);

    localparam int OFS = $clog2(LINE_SIZE / 8);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_IC_BUSY,
        ST_DC_RD,
        ST_DC_WR,
        ST_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic                   last_dc_q, last_dc_d;
    logic                   mem_read_q, mem_read_d;
    logic                   mem_write_q, mem_write_d;
    logic [WORD_SIZE-1:0]   mem_addr_q, mem_addr_d;
    logic [LINE_SIZE-1:0]   mem_wline_q, mem_wline_d;
    logic [LINE_SIZE-1:0]   ic_line_q, ic_line_d;
    logic [LINE_SIZE-1:0]   dc_line_q, dc_line_d;
    logic                   ic_ready_q, ic_ready_d;
    logic                   dc_ready_q, dc_ready_d;
    logic [CNT_W-1:0]       ic_grants_q, ic_grants_d;
    logic [CNT_W-1:0]       dc_grants_q, dc_grants_d;
    logic                   proto_err_q, proto_err_d;
    logic                   grant_dc;

    function automatic logic [WORD_SIZE-1:0] line_align(input logic [WORD_SIZE-1:0] a);
        return {a[WORD_SIZE-1:OFS], {OFS{1'b0}}};
    endfunction

    always_comb begin
        // NOTE: every signal gets its hold/idle value first so no path can infer a latch.
        state_d     = state_q;
        last_dc_d   = last_dc_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        mem_addr_d  = mem_addr_q;
        mem_wline_d = mem_wline_q;
        ic_line_d   = ic_line_q;
        dc_line_d   = dc_line_q;
        ic_ready_d  = 1'b0;
        dc_ready_d  = 1'b0;
        ic_grants_d = ic_grants_q;
        dc_grants_d = dc_grants_q;
        proto_err_d = proto_err_q;
        grant_dc    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                proto_err_d = proto_err_q | (dc_rd_req & dc_wr_req);
                // On contention the side that was not served last wins.
                grant_dc = (dc_rd_req | dc_wr_req) & (~ic_req | ~last_dc_q);
                if (grant_dc) begin
                    last_dc_d  = 1'b1;
                    mem_addr_d = line_align(dc_addr);
                    if (dc_wr_req) begin
                        state_d     = ST_DC_WR;
                        mem_write_d = 1'b1;
                        mem_wline_d = dc_wline;
                    end else begin
                        state_d    = ST_DC_RD;
                        mem_read_d = 1'b1;
                    end
                end else if (ic_req) begin
                    last_dc_d  = 1'b0;
                    state_d    = ST_IC_BUSY;
                    mem_read_d = 1'b1;
                    mem_addr_d = line_align(ic_addr);
                end
            end
            ST_IC_BUSY, ST_DC_RD, ST_DC_WR: begin
                if (mem_ready) begin
                    state_d     = ST_DONE;
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    mem_addr_d  = '0;
                    mem_wline_d = '0;
                    if (state_q == ST_IC_BUSY) begin
                        ic_line_d  = mem_rline;
                        ic_ready_d = 1'b1;
                        if (ic_grants_q != '1) ic_grants_d = ic_grants_q + CNT_W'(1);
                    end else begin
                        if (state_q == ST_DC_RD) dc_line_d = mem_rline;
                        dc_ready_d = 1'b1;
                        if (dc_grants_q != '1) dc_grants_d = dc_grants_q + CNT_W'(1);
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            last_dc_q   <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wline_q <= '0;
            ic_line_q   <= '0;
            dc_line_q   <= '0;
            ic_ready_q  <= 1'b0;
            dc_ready_q  <= 1'b0;
            ic_grants_q <= '0;
            dc_grants_q <= '0;
            proto_err_q <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so every flop samples the pre-edge value of the others.
            state_q     <= state_d;
            last_dc_q   <= last_dc_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_wline_q <= mem_wline_d;
            ic_line_q   <= ic_line_d;
            dc_line_q   <= dc_line_d;
            ic_ready_q  <= ic_ready_d;
            dc_ready_q  <= dc_ready_d;
            ic_grants_q <= ic_grants_d;
            dc_grants_q <= dc_grants_d;
            proto_err_q <= proto_err_d;
        end
    end

    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wline = mem_wline_q;
    assign ic_line   = ic_line_q;
    assign dc_line   = dc_line_q;
    assign ic_ready  = ic_ready_q;
    assign dc_ready  = dc_ready_q;
    assign ic_grants = ic_grants_q;
    assign dc_grants = dc_grants_q;
    assign proto_err = proto_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: transaction-level reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic with a latency-varying memory.
module tb_mem_arbiter;

    localparam int W          = 32;
    localparam int L          = 128;
    localparam int CW         = 4;
    localparam int CNT_MAX    = (1 << CW) - 1;
    localparam int LINE_BYTES = L / 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ic_req = 1'b0;
    logic [W-1:0]  ic_addr = '0;
    logic          dc_rd_req = 1'b0;
    logic          dc_wr_req = 1'b0;
    logic [W-1:0]  dc_addr = '0;
    logic [L-1:0]  dc_wline = '0;
    logic [L-1:0]  mem_rline = '0;
    logic          mem_ready = 1'b0;

    logic [L-1:0]  ic_line, dc_line, mem_wline;
    logic          ic_ready, dc_ready, mem_read, mem_write, proto_err;
    logic [W-1:0]  mem_addr;
    logic [CW-1:0] ic_grants, dc_grants;

    mem_arbiter #(.WORD_SIZE(W), .LINE_SIZE(L), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .ic_req(ic_req), .ic_addr(ic_addr), .ic_line(ic_line), .ic_ready(ic_ready),
        .dc_rd_req(dc_rd_req), .dc_wr_req(dc_wr_req), .dc_addr(dc_addr), .dc_wline(dc_wline),
        .dc_line(dc_line), .dc_ready(dc_ready),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wline(mem_wline),
        .mem_rline(mem_rline), .mem_ready(mem_ready),
        .ic_grants(ic_grants), .dc_grants(dc_grants), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [L-1:0] act, input logic [L-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (transaction level) ----------------
    typedef enum int {K_NONE, K_IC, K_DRD, K_DWR} kind_e;

    kind_e         m_kind = K_NONE;
    bit            m_gap = 1'b0;      // the one idle-ignoring cycle after a completion
    bit            m_last_dc = 1'b0;
    bit            model_ok = 1'b0;
    logic          exp_mem_read = 0, exp_mem_write = 0, exp_ic_ready = 0, exp_dc_ready = 0;
    logic          exp_proto_err = 0;
    logic [W-1:0]  exp_mem_addr = '0;
    logic [L-1:0]  exp_mem_wline = '0, exp_ic_line = '0, exp_dc_line = '0;
    logic [CW-1:0] exp_ic_grants = '0, exp_dc_grants = '0;

    function automatic logic [W-1:0] line_base(input logic [W-1:0] a);
        return a - (a % LINE_BYTES);
    endfunction

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
        if (int'(c) == CNT_MAX) return c;
        return c + 1'b1;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_kind = K_NONE; m_gap = 0; m_last_dc = 0; model_ok = 1;
            exp_mem_read = 0; exp_mem_write = 0; exp_ic_ready = 0; exp_dc_ready = 0;
            exp_proto_err = 0; exp_mem_addr = '0; exp_mem_wline = '0;
            exp_ic_line = '0; exp_dc_line = '0; exp_ic_grants = '0; exp_dc_grants = '0;
        end else begin
            exp_ic_ready = 0;
            exp_dc_ready = 0;
            if (m_kind != K_NONE) begin
                if (mem_ready) begin
                    if (m_kind == K_IC) begin
                        exp_ic_line = mem_rline; exp_ic_ready = 1;
                        exp_ic_grants = sat_inc(exp_ic_grants);
                    end else begin
                        if (m_kind == K_DRD) exp_dc_line = mem_rline;
                        exp_dc_ready = 1;
                        exp_dc_grants = sat_inc(exp_dc_grants);
                    end
                    m_kind = K_NONE; m_gap = 1;
                    exp_mem_read = 0; exp_mem_write = 0; exp_mem_addr = '0; exp_mem_wline = '0;
                end
            end else if (m_gap) begin
                m_gap = 0;
            end else begin
                if (dc_rd_req && dc_wr_req) exp_proto_err = 1;
                if ((dc_rd_req || dc_wr_req) && (!ic_req || !m_last_dc)) begin
                    m_kind = dc_wr_req ? K_DWR : K_DRD;
                    m_last_dc = 1;
                    exp_mem_addr = line_base(dc_addr);
                    exp_mem_read = !dc_wr_req;
                    exp_mem_write = dc_wr_req;
                    exp_mem_wline = dc_wr_req ? dc_wline : '0;
                end else if (ic_req) begin
                    m_kind = K_IC;
                    m_last_dc = 0;
                    exp_mem_addr = line_base(ic_addr);
                    exp_mem_read = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (model_ok) begin
            check("mem_read", mem_read, exp_mem_read);
            check("mem_write", mem_write, exp_mem_write);
            check("mem_addr", mem_addr, exp_mem_addr);
            check("mem_wline", mem_wline, exp_mem_wline);
            check("ic_ready", ic_ready, exp_ic_ready);
            check("dc_ready", dc_ready, exp_dc_ready);
            check("ic_line", ic_line, exp_ic_line);
            check("dc_line", dc_line, exp_dc_line);
            check("ic_grants", ic_grants, exp_ic_grants);
            check("dc_grants", dc_grants, exp_dc_grants);
            check("proto_err", proto_err, exp_proto_err);
            check("both_ready", ic_ready & dc_ready, 1'b0);
            check("both_strobes", mem_read & mem_write, 1'b0);
        end
    end

    // ---------------- backing memory ----------------
    int           mem_lat = 3;       // 0 selects a random latency per transaction
    int           m_cnt = 0;
    int           cur_lat = 1;
    bit           stray_en = 0;
    bit           fixed_en = 0;
    logic [L-1:0] fixed_data = '0;
    int           stray_req = 0;
    int           stray_done = 0;

    always @(negedge clk) begin
        mem_ready = 1'b0;
        if (mem_read || mem_write) begin
            if (m_cnt == 0) cur_lat = (mem_lat == 0) ? int'($urandom_range(1, 4)) : mem_lat;
            m_cnt++;
            if (m_cnt >= cur_lat) begin
                mem_ready = 1'b1;
                mem_rline = fixed_en ? fixed_data : {$urandom, $urandom, $urandom, $urandom};
                m_cnt = 0;
            end
        end else begin
            m_cnt = 0;
            if (stray_done != stray_req || (stray_en && $urandom_range(0, 19) == 0)) begin
                mem_ready = 1'b1;
                mem_rline = {$urandom, $urandom, $urandom, $urandom};
                stray_done = stray_req;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1; ic_req = 0; dc_rd_req = 0; dc_wr_req = 0;
        repeat (2) step();
        rst = 0;
    endtask

    task automatic wait_ready(input bit dc_side, input string name);
        int n = 0;
        while (!(dc_side ? dc_ready : ic_ready) && n < 40) begin
            step();
            n++;
        end
        check(name, dc_side ? dc_ready : ic_ready, 1'b1);
    endtask

    initial begin
        int   n, ic_done, dc_done, budget;
        int   order[$];
        bit   saw_rd, saw_wr, seen;
        logic [W-1:0] wr_addr;
        logic [L-1:0] wr_line;
        logic [L-1:0] rd_data;

        // Test 1: single iCache refill, 3-cycle memory
        do_reset();
        check("rst_ic_grants", ic_grants, 0);
        check("rst_ic_line", ic_line, 0);
        check("rst_mem_read", mem_read, 0);
        check("rst_proto_err", proto_err, 0);
        mem_lat = 3; fixed_en = 1;
        fixed_data = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        ic_addr = 32'h0000_104C; ic_req = 1;
        step();
        check("t1_mem_read", mem_read, 1);
        check("t1_mem_addr", mem_addr, 32'h0000_1040);
        n = 0;
        while (!ic_ready && n < 20) begin step(); n++; end
        check("t1_latency", n, 3);
        check("t1_ic_line", ic_line, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);
        check("t1_ic_grants", ic_grants, 1);
        ic_req = 0;
        step();
        check("t1_ready_one_cycle", ic_ready, 0);

        // Test 2: simultaneous requests alternate, DC first after reset
        do_reset();
        mem_lat = 0; fixed_en = 0;
        ic_addr = 32'h0000_5004; dc_addr = 32'h0000_6008;
        ic_req = 1; dc_rd_req = 1;
        ic_done = 0; dc_done = 0; budget = 400;
        while ((ic_done < 4 || dc_done < 4) && budget > 0) begin
            step();
            budget--;
            if (ic_ready) begin ic_done++; order.push_back(0); ic_req = 0; end
            else ic_req = (ic_done < 4);
            if (dc_ready) begin dc_done++; order.push_back(1); dc_rd_req = 0; end
            else dc_rd_req = (dc_done < 4);
        end
        ic_req = 0; dc_rd_req = 0;
        check("t2_count", order.size(), 8);
        foreach (order[i]) check("t2_order", order[i], (i % 2 == 0) ? 1 : 0);
        check("t2_ic_grants", ic_grants, 4);
        check("t2_dc_grants", dc_grants, 4);

        // Test 3: dCache read, then write-back leaves dc_line alone
        do_reset();
        fixed_en = 1; rd_data = 128'hAAAA_0001_BBBB_0002_CCCC_0003_DDDD_0004;
        fixed_data = rd_data;
        dc_addr = 32'h0000_7010; dc_rd_req = 1;
        step();
        wait_ready(1'b1, "t3_rd_ready");
        dc_rd_req = 0;
        check("t3_dc_line", dc_line, 128'hAAAA_0001_BBBB_0002_CCCC_0003_DDDD_0004);
        step();
        dc_wline = {4{32'hDEAD_BEEF}}; dc_addr = 32'h0000_2008; dc_wr_req = 1;
        saw_rd = 0; saw_wr = 0; wr_addr = '0; wr_line = '0; n = 0;
        while (!dc_ready && n < 40) begin
            step(); n++;
            if (mem_read) saw_rd = 1;
            if (mem_write) begin saw_wr = 1; wr_addr = mem_addr; wr_line = mem_wline; end
        end
        dc_wr_req = 0;
        check("t3_wr_ready", dc_ready, 1);
        check("t3_saw_write", saw_wr, 1);
        check("t3_no_read", saw_rd, 0);
        check("t3_wr_addr", wr_addr, 32'h0000_2000);
        check("t3_wr_line", wr_line, {4{32'hDEAD_BEEF}});
        check("t3_dc_line_kept", dc_line, 128'hAAAA_0001_BBBB_0002_CCCC_0003_DDDD_0004);
        check("t3_dc_grants", dc_grants, 2);

        // Test 4: read and write together -> write wins, sticky proto_err
        step();
        dc_rd_req = 1; dc_wr_req = 1; dc_addr = 32'h0000_3000;
        step();
        check("t4_write", mem_write, 1);
        check("t4_no_read", mem_read, 0);
        check("t4_proto", proto_err, 1);
        wait_ready(1'b1, "t4_ready");
        dc_rd_req = 0; dc_wr_req = 0;
        repeat (5) step();
        check("t4_proto_sticky", proto_err, 1);
        do_reset();
        check("t4_proto_cleared", proto_err, 0);

        // Test 5: reset two cycles into IC_BUSY, then a stray mem_ready in IDLE
        mem_lat = 8; fixed_en = 0;
        ic_addr = 32'h0000_3004; ic_req = 1;
        step();
        check("t5_busy", mem_read, 1);
        step();
        rst = 1;
        step();
        check("t5_rst_read", mem_read, 0);
        check("t5_rst_addr", mem_addr, 0);
        check("t5_rst_ready", ic_ready, 0);
        check("t5_rst_grants", ic_grants, 0);
        rst = 0; ic_req = 0;
        seen = 0;
        repeat (10) begin step(); if (ic_ready || dc_ready) seen = 1; end
        check("t5_no_ready_after_rst", seen, 0);
        stray_req++;
        repeat (4) begin step(); if (ic_ready || dc_ready) seen = 1; end
        check("t5_stray_sent", stray_done, stray_req);
        check("t5_stray_ignored", seen, 0);

        // Test 6: counter saturation with 2^CW+3 transactions
        do_reset();
        mem_lat = 1;
        for (int k = 0; k < (1 << CW) + 3; k++) begin
            ic_addr = $urandom; ic_req = 1;
            step();
            wait_ready(1'b0, "t6_ready");
            ic_req = 0;
            step();
            if (k == CNT_MAX - 1) check("t6_at_max", ic_grants, 4'hF);
        end
        check("t6_saturated", ic_grants, 4'hF);

        // Randomized traffic
        do_reset();
        mem_lat = 0; stray_en = 1;
        for (int c = 0; c < 4000; c++) begin
            step();
            if (rst) rst = 0;
            else if ($urandom_range(0, 399) == 0) rst = 1;
            if (ic_ready) ic_req = 0;
            else if (!ic_req && $urandom_range(0, 3) == 0) begin
                ic_req = 1; ic_addr = $urandom;
            end else if (ic_req && $urandom_range(0, 49) == 0) ic_req = 0;
            if (dc_ready) begin dc_rd_req = 0; dc_wr_req = 0; end
            else if (!dc_rd_req && !dc_wr_req && $urandom_range(0, 3) == 0) begin
                dc_addr = $urandom;
                dc_wline = {$urandom, $urandom, $urandom, $urandom};
                case ($urandom_range(0, 19))
                    0:       begin dc_rd_req = 1; dc_wr_req = 1; end
                    1,2,3,4,5,6,7,8,9: dc_wr_req = 1;
                    default: dc_rd_req = 1;
                endcase
            end
        end
        stray_en = 0;
        ic_req = 0; dc_rd_req = 0; dc_wr_req = 0;
        repeat (10) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
